// File: rtl/dmr_mon_pkg.sv
// Shared state encoding for the DMR counter monitor.
// MON_HALT_ON_ERR_EN selects whether a resolved mismatch parks the monitor in HALT.
package dmr_mon_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_REPORT = 3'd2,
        ST_SYNC   = 3'd3,
        ST_HALT   = 3'd4
    } mon_state_e;

`ifdef MON_HALT_ON_ERR_EN
    localparam mon_state_e POST_SYNC = ST_HALT;
`else
    localparam mon_state_e POST_SYNC = ST_RUN;
`endif

endpackage

// File: rtl/dmr_counter_lane.sv
// One counter lane: increment, clear, parallel load and single-bit flip.
module dmr_counter_lane #(
    parameter int CNT_W = 28
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     ld,
    input  logic [CNT_W-1:0]         ld_val,
    input  logic                     flip_en,
    input  logic [$clog2(CNT_W)-1:0] flip_idx,
    output logic [CNT_W-1:0]         q
);

    logic [CNT_W-1:0] flip_mask;

    // Out-of-range indices simply match no bit, so they flip nothing.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < CNT_W; i++)
            if (flip_en && flip_idx == ($clog2(CNT_W))'(i))
                flip_mask[i] = 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else
            q <= (q + CNT_W'(en)) ^ flip_mask;
    end

endmodule

// File: rtl/dmr_counter_monitor.sv
// Lockstep DMR counter with mismatch detection, syndrome handshake and lane-B resync.
// MON_HALT_ON_ERR_EN (see dmr_mon_pkg) parks the monitor in HALT after each resync.
module dmr_counter_monitor
    import dmr_mon_pkg::*;
#(
    parameter int CNT_W = 28,
    parameter int OUT_W = 4,
    parameter int ERR_W = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     inj_valid,
    input  logic [$clog2(CNT_W)-1:0] inj_bit,
    output logic [OUT_W-1:0]         cntout,
    output logic [STATE_W-1:0]       state,
    output logic [ERR_W-1:0]         err_count,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [CNT_W-1:0]         evt_data
);

    mon_state_e       st;
    logic [CNT_W-1:0] lane_a, lane_b;
    logic             mismatch, cnt_en, flip_en, sync;

    assign mismatch = (st == ST_RUN) && (lane_a != lane_b);
    assign cnt_en   = (st == ST_RUN) && !mismatch;
    assign flip_en  = inj_valid && (st != ST_SYNC);
    assign sync     = (st == ST_SYNC);

    dmr_counter_lane #(.CNT_W(CNT_W)) u_lane_a (
        .clk(clk), .nreset(nreset), .en(cnt_en), .clr(clear),
        .ld(1'b0), .ld_val('0), .flip_en(1'b0), .flip_idx('0), .q(lane_a)
    );

    // Only lane B is a fault-injection target and gets realigned to lane A.
    dmr_counter_lane #(.CNT_W(CNT_W)) u_lane_b (
        .clk(clk), .nreset(nreset), .en(cnt_en), .clr(clear),
        .ld(sync), .ld_val(lane_a), .flip_en(flip_en), .flip_idx(inj_bit), .q(lane_b)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            st        <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_data  <= '0;
            err_count <= '0;
        end else if (clear) begin
            st        <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_data  <= '0;
            err_count <= '0;
        end else begin
            case (st)
                ST_IDLE:   if (start) st <= ST_RUN;
                ST_RUN: begin
                    if (mismatch) begin
                        st        <= ST_REPORT;
                        evt_valid <= 1'b1;
                        evt_data  <= lane_a ^ lane_b;
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                    end else if (stop) begin
                        st <= ST_IDLE;
                    end
                end
                ST_REPORT: begin
                    if (evt_ready) begin
                        st        <= ST_SYNC;
                        evt_valid <= 1'b0;
                    end
                end
                ST_SYNC:   st <= POST_SYNC;
                ST_HALT:   ;
                default:   st <= ST_IDLE;
            endcase
        end
    end

    assign state  = st;
    assign cntout = lane_a[CNT_W-1 -: OUT_W];

endmodule

// File: tb/tb_dmr_counter_monitor.sv
// Directed bench: full-width monitor plus a 4-bit/2-bit-error instance for wrap and saturation.
module tb_dmr_counter_monitor;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 0, stop = 0, clear = 0, inj_valid = 0, evt_ready = 0;
    logic [4:0]  inj_bit = '0;
    logic [3:0]  cntout;
    logic [2:0]  state;
    logic [15:0] err_count;
    logic        evt_valid;
    logic [27:0] evt_data;

    logic        s_start = 0, s_stop = 0, s_clear = 0, s_inj_valid = 0, s_evt_ready = 0;
    logic [1:0]  s_inj_bit = '0;
    logic [3:0]  s_cntout;
    logic [2:0]  s_state;
    logic [1:0]  s_err_count;
    logic        s_evt_valid;
    logic [3:0]  s_evt_data;

    int checks = 0;
    int errors = 0;

    dmr_counter_monitor #(.CNT_W(28), .OUT_W(4), .ERR_W(16)) dut (
        .clk(clk), .nreset(nreset), .start(start), .stop(stop), .clear(clear),
        .inj_valid(inj_valid), .inj_bit(inj_bit), .cntout(cntout), .state(state),
        .err_count(err_count), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data)
    );

    dmr_counter_monitor #(.CNT_W(4), .OUT_W(4), .ERR_W(2)) dut2 (
        .clk(clk), .nreset(nreset), .start(s_start), .stop(s_stop), .clear(s_clear),
        .inj_valid(s_inj_valid), .inj_bit(s_inj_bit), .cntout(s_cntout), .state(s_state),
        .err_count(s_err_count), .evt_valid(s_evt_valid), .evt_ready(s_evt_ready), .evt_data(s_evt_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b exp 0", evt_valid); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        checks++; if (evt_data !== 28'd0) begin errors++; $display("FAIL reset_evt_data got %h exp 0", evt_data); end
        checks++; if (cntout !== 4'd0 || s_cntout !== 4'd0) begin errors++; $display("FAIL reset_cntout got %h/%h exp 0/0", cntout, s_cntout); end
        checks++; if (dut.lane_a !== 28'd0 || dut.lane_b !== 28'd0) begin errors++; $display("FAIL reset_lanes got %h/%h exp 0/0", dut.lane_a, dut.lane_b); end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_count();
        start = 1; tick(); start = 0;
        repeat (100) tick();
        checks++; if (dut.lane_a !== 28'd100 || dut.lane_b !== 28'd100) begin errors++; $display("FAIL count_lanes got %0d/%0d exp 100/100", dut.lane_a, dut.lane_b); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL count_state got %0d exp 1", state); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL count_evt_valid got %b exp 0", evt_valid); end
        checks++; if (cntout !== 4'd0) begin errors++; $display("FAIL count_cntout got %h exp 0", cntout); end
    endtask

    task automatic test_inject();
        inj_valid = 1; inj_bit = 5'd3; tick(); inj_valid = 0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL inj_early_valid got %b exp 0", evt_valid); end
        tick();
        checks++; if (evt_valid !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL inj_report got valid %b state %0d exp 1 2", evt_valid, state); end
        checks++; if (evt_data !== 28'h0000008) begin errors++; $display("FAIL inj_syndrome got %h exp 0000008", evt_data); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL inj_err_count got %0d exp 1", err_count); end
        // stop/start must not disturb a pending report
        stop = 1; start = 1; tick(); stop = 0; start = 0;
        repeat (9) tick();
        checks++; if (evt_valid !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL hold_report got valid %b state %0d exp 1 2", evt_valid, state); end
        checks++; if (evt_data !== 28'h0000008) begin errors++; $display("FAIL hold_syndrome got %h exp 0000008", evt_data); end
        checks++; if (dut.lane_a !== 28'd101 || dut.lane_b !== 28'd109) begin errors++; $display("FAIL hold_frozen got %0d/%0d exp 101/109", dut.lane_a, dut.lane_b); end
    endtask

    task automatic test_accept();
        evt_ready = 1; tick(); evt_ready = 0;
        checks++; if (state !== 3'd3 || evt_valid !== 1'b0) begin errors++; $display("FAIL acc_sync got state %0d valid %b exp 3 0", state, evt_valid); end
        tick();
        checks++; if (dut.lane_a !== 28'd101 || dut.lane_b !== 28'd101) begin errors++; $display("FAIL acc_resync got %0d/%0d exp 101/101", dut.lane_a, dut.lane_b); end
`ifdef MON_HALT_ON_ERR_EN
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL acc_halt got %0d exp 4", state); end
        start = 1; tick(); start = 0;
        repeat (3) tick();
        checks++; if (state !== 3'd4 || dut.lane_a !== 28'd101) begin errors++; $display("FAIL halt_hold got state %0d lane %0d exp 4 101", state, dut.lane_a); end
        clear = 1; tick(); clear = 0;
        checks++; if (state !== 3'd0 || err_count !== 16'd0) begin errors++; $display("FAIL halt_clear got state %0d err %0d exp 0 0", state, err_count); end
`else
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL acc_run got %0d exp 1", state); end
        repeat (5) tick();
        checks++; if (dut.lane_a !== 28'd106 || dut.lane_b !== 28'd106) begin errors++; $display("FAIL acc_resume got %0d/%0d exp 106/106", dut.lane_a, dut.lane_b); end
        checks++; if (evt_valid !== 1'b0 || err_count !== 16'd1) begin errors++; $display("FAIL acc_quiet got valid %b err %0d exp 0 1", evt_valid, err_count); end
`endif
    endtask

    task automatic test_ignored_idx();
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
        inj_valid = 1; inj_bit = 5'd30; tick(); inj_valid = 0;
        repeat (3) tick();
        checks++; if (dut.lane_a !== 28'd4 || dut.lane_b !== 28'd4) begin errors++; $display("FAIL bad_idx_lanes got %0d/%0d exp 4/4", dut.lane_a, dut.lane_b); end
        checks++; if (state !== 3'd1 || evt_valid !== 1'b0) begin errors++; $display("FAIL bad_idx_state got %0d valid %b exp 1 0", state, evt_valid); end
    endtask

    task automatic test_stop_mismatch();
        inj_valid = 1; inj_bit = 5'd0; tick(); inj_valid = 0;
        stop = 1; tick(); stop = 0;
        checks++; if (state !== 3'd2 || evt_valid !== 1'b1) begin errors++; $display("FAIL stop_vs_err got state %0d valid %b exp 2 1", state, evt_valid); end
        checks++; if (evt_data !== 28'h0000001 || err_count !== 16'd1) begin errors++; $display("FAIL stop_vs_err_data got %h err %0d exp 0000001 1", evt_data, err_count); end
        checks++; if (dut.lane_a !== 28'd5 || dut.lane_b !== 28'd4) begin errors++; $display("FAIL stop_vs_err_lanes got %0d/%0d exp 5/4", dut.lane_a, dut.lane_b); end
        clear = 1; tick(); clear = 0;
        checks++; if (state !== 3'd0 || evt_valid !== 1'b0 || err_count !== 16'd0) begin errors++; $display("FAIL clr_report got state %0d valid %b err %0d exp 0 0 0", state, evt_valid, err_count); end
        checks++; if (dut.lane_a !== 28'd0 || dut.lane_b !== 28'd0 || evt_data !== 28'd0) begin errors++; $display("FAIL clr_lanes got %h/%h data %h exp 0", dut.lane_a, dut.lane_b, evt_data); end
    endtask

    task automatic test_idle_inject();
        inj_valid = 1; inj_bit = 5'd27; tick(); inj_valid = 0;
        checks++; if (state !== 3'd0 || dut.lane_b !== 28'h8000000 || cntout !== 4'd0) begin errors++; $display("FAIL idle_inj got state %0d laneB %h cnt %h exp 0 8000000 0", state, dut.lane_b, cntout); end
        start = 1; tick(); start = 0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL idle_inj_run got %0d exp 1", state); end
        tick();
        checks++; if (state !== 3'd2 || evt_data !== 28'h8000000 || err_count !== 16'd1) begin errors++; $display("FAIL idle_inj_detect got state %0d data %h err %0d exp 2 8000000 1", state, evt_data, err_count); end
        evt_ready = 1; tick(); evt_ready = 0;
        tick();
`ifdef MON_HALT_ON_ERR_EN
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL idle_inj_post got %0d exp 4", state); end
`else
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL idle_inj_post got %0d exp 1", state); end
`endif
        checks++; if (dut.lane_a !== 28'd0 || dut.lane_b !== 28'd0) begin errors++; $display("FAIL idle_inj_sync got %h/%h exp 0/0", dut.lane_a, dut.lane_b); end
    endtask

    task automatic test_clear_inj();
        clear = 1; inj_valid = 1; inj_bit = 5'd5; tick(); clear = 0; inj_valid = 0;
        checks++; if (state !== 3'd0 || dut.lane_b !== 28'd0) begin errors++; $display("FAIL clr_inj got state %0d laneB %h exp 0 0", state, dut.lane_b); end
        start = 1; tick(); start = 0;
        repeat (3) tick();
        checks++; if (dut.lane_a !== 28'd3 || dut.lane_b !== 28'd3 || evt_valid !== 1'b0) begin errors++; $display("FAIL clr_inj_run got %0d/%0d valid %b exp 3/3 0", dut.lane_a, dut.lane_b, evt_valid); end
    endtask

    task automatic test_wrap();
        s_start = 1; tick(); s_start = 0;
        repeat (14) tick();
        checks++; if (s_cntout !== 4'hE) begin errors++; $display("FAIL wrap_pre got %h exp e", s_cntout); end
        repeat (3) tick();
        checks++; if (s_cntout !== 4'h1 || dut2.lane_b !== 4'h1) begin errors++; $display("FAIL wrap_post got %h/%h exp 1/1", s_cntout, dut2.lane_b); end
        checks++; if (s_evt_valid !== 1'b0 || s_state !== 3'd1) begin errors++; $display("FAIL wrap_quiet got valid %b state %0d exp 0 1", s_evt_valid, s_state); end
    endtask

    task automatic test_saturate();
`ifndef MON_HALT_ON_ERR_EN
        for (int k = 1; k <= 5; k++) begin
            s_inj_valid = 1; s_inj_bit = 2'd0; tick(); s_inj_valid = 0;
            tick();
            checks++; if (s_evt_valid !== 1'b1 || s_evt_data !== 4'h1) begin errors++; $display("FAIL sat_evt%0d got valid %b data %h exp 1 1", k, s_evt_valid, s_evt_data); end
            checks++; if (s_err_count !== ((k > 3) ? 2'd3 : 2'(k))) begin errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", k, s_err_count, (k > 3) ? 3 : k); end
            s_evt_ready = 1; tick(); s_evt_ready = 0;
            tick();
        end
        checks++; if (s_err_count !== 2'd3 || s_state !== 3'd1) begin errors++; $display("FAIL sat_final got err %0d state %0d exp 3 1", s_err_count, s_state); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_inject();
        test_accept();
        test_ignored_idx();
        test_stop_mismatch();
        test_idle_inject();
        test_clear_inj();
        test_wrap();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
